// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
// It reports the occupancy count, the full, empty, almost-full and
// almost-empty flags, and sticky overflow/underflow error flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN.
//   - Undefined: registered read with 1-cycle latency.
//   - Defined: first-word-fall-through. The head word is shown combinationally.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_wr,
    input  logic [DATA_W-1:0]         i_wdata_in,
    input  logic                      i_rd,
    input  logic                      i_clr_err,
    output logic [DATA_W-1:0]         o_rdata_out,
    output logic                      o_rvalid,
    output logic                      o_wfull,
    output logic                      o_rempty,
    output logic                      o_afull,
    output logic                      o_aempty,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_overflow,
    output logic                      o_underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AFULL  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] C_AEMPTY = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr, r_rptr, r_count, w_count_nxt;
    logic              r_overflow, r_underflow;
    logic              w_full, w_empty, w_wr_ok, w_rd_ok;

    // The flags decode only the registered count. They never decode the
    // requests, so acceptance is judged on the state at the start of the cycle.
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_ok  = i_wr && !w_full;
    assign w_rd_ok  = i_rd && !w_empty;

    assign o_wfull     = w_full;
    assign o_rempty    = w_empty;
    assign o_afull     = (r_count >= C_AFULL);
    assign o_aempty    = (r_count <= C_AEMPTY);
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // Storage write. The array has no reset because its contents are
    // don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wptr[ADDR_W-1:0]] <= i_wdata_in;
    end

    // Next occupancy. A simultaneous accepted push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok)      w_count_nxt = r_count + 1'b1;
        else if (w_rd_ok && !w_wr_ok) w_count_nxt = r_count - 1'b1;
    end

    // Pointers and count. Each pointer has an extra MSB as the wrap bit and
    // wraps modulo 2*DEPTH.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // Sticky error flags. If a set and a clear occur in the same cycle,
    // the set wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr && w_full)  r_overflow <= 1'b1;
            else if (i_clr_err)  r_overflow <= 1'b0;
            if (i_rd && w_empty) r_underflow <= 1'b1;
            else if (i_clr_err)  r_underflow <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The head word is visible whenever the FIFO is not empty.
    // A write into an empty FIFO shows up after the count updates.
    assign o_rdata_out = r_mem[r_rptr[ADDR_W-1:0]];
    assign o_rvalid    = !w_empty;
`else
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    // Registered read. The strobe pulses for one cycle per accepted pop.
    // The data holds its last value until the next pop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_ok;
            if (w_rd_ok) r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
        end
    end

    assign o_rdata_out = r_rdata;
    assign o_rvalid    = r_rvalid;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for sync_fifo_param
// (DATA_W=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
// The stimulus queues the expected read words.
// A monitor pops the queue and compares each word the DUT presents.
module tb_sync_fifo_param;
    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_wr = 1'b0, i_rd = 1'b0, i_clr_err = 1'b0;
    logic [7:0] i_wdata_in = '0;
    logic [7:0] o_rdata_out;
    logic       o_rvalid, o_wfull, o_rempty, o_afull, o_aempty;
    logic [3:0] o_count;
    logic       o_overflow, o_underflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_wdata_in(i_wdata_in),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_rdata_out(o_rdata_out),
        .o_rvalid(o_rvalid), .o_wfull(o_wfull), .o_rempty(o_rempty),
        .o_afull(o_afull), .o_aempty(o_aempty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of requests. Inputs are applied 1 time unit after a rising edge.
    // Outputs are settled 1 time unit after the edge that consumes them.
    task automatic cyc(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        i_wr = wr; i_wdata_in = wd; i_rd = rd; i_clr_err = clr;
        @(posedge i_clk); #1;
        i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
    endtask

    // Monitor. It compares each presented read word against the scoreboard.
    always @(negedge i_clk) begin
`ifdef SYNC_FIFO_FWFT_EN
        if (i_reset_n && o_rvalid && i_rd) begin
`else
        if (i_reset_n && o_rvalid) begin
`endif
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rdata_unexpected: got 0x%0h expected none", o_rdata_out);
            end else begin
                chk("rdata", {24'h0, o_rdata_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_count", o_count, 0);   chk("rst_rempty", o_rempty, 1);
        chk("rst_wfull", o_wfull, 0);   chk("rst_aempty", o_aempty, 1);
        chk("rst_afull", o_afull, 0);   chk("rst_ovf", o_overflow, 0);
        chk("rst_unf", o_underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rvalid", o_rvalid, 0); chk("rst_rdata", o_rdata_out, 0);
`endif
        @(negedge i_clk); i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Test 1: fill the FIFO with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 8'(8'h11 * i), 0, 0);
            chk("t1_count", o_count, i);
            chk("t1_aempty", o_aempty, (i <= 2) ? 1 : 0);
            chk("t1_afull", o_afull, (i >= 6) ? 1 : 0);
            chk("t1_wfull", o_wfull, (i == 8) ? 1 : 0);
        end
        chk("t1_ovf", o_overflow, 0);

        // Test 2: overflow, then drain in order
        cyc(1, 8'h99, 0, 0);
        chk("t2_ovf", o_overflow, 1); chk("t2_count", o_count, 8);
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(8'h11 * i));
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0);
        chk("t2_count_end", o_count, 0); chk("t2_rempty", o_rempty, 1);
        chk("t2_rvalid_idle", o_rvalid, 0);

        // Test 3: underflow and clear
        cyc(0, 0, 1, 0);
        chk("t3_unf", o_underflow, 1); chk("t3_rvalid", o_rvalid, 0);
        chk("t3_count", o_count, 0);
        cyc(0, 0, 0, 1);
        chk("t3_unf_clr", o_underflow, 0); chk("t3_ovf_clr", o_overflow, 0);
        cyc(0, 0, 1, 1);
        chk("t3_set_wins", o_underflow, 1);
        cyc(0, 0, 0, 1);

        // Test 4: steady state at count 4 with concurrent push/pop, many wraps
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0);
        chk("t4_count_init", o_count, 4);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            cyc(1, 8'(8'h24 + i), 1, 0);
            chk("t4_count", o_count, 4);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'h34 + i));
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0);
        chk("t4_count_end", o_count, 0);
        chk("t4_no_err", {30'h0, o_overflow, o_underflow}, 0);

        // Test 5: full with both requests, then empty with both requests
        for (int i = 0; i < 8; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        chk("t5_full", o_wfull, 1);
        exp_q.push_back(8'h40);
        cyc(1, 8'h50, 1, 0);
        chk("t5_count7", o_count, 7); chk("t5_ovf", o_overflow, 1);
        for (int i = 1; i < 8; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 1);
        chk("t5_empty", o_rempty, 1); chk("t5_ovf_clr", o_overflow, 0);
        cyc(1, 8'h60, 1, 0);
        chk("t5_count1", o_count, 1); chk("t5_unf", o_underflow, 1);
        exp_q.push_back(8'h60);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk("t5_count_end", o_count, 0); chk("t5_unf_clr", o_underflow, 0);

        // Test 6: asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h70 + i), 0, 0);
        chk("t6_count5", o_count, 5);
        i_wr = 1'b1; i_wdata_in = 8'h75;
        #2 i_reset_n = 1'b0;
        #1;
        chk("t6_count", o_count, 0);   chk("t6_rempty", o_rempty, 1);
        chk("t6_wfull", o_wfull, 0);   chk("t6_aempty", o_aempty, 1);
        chk("t6_afull", o_afull, 0);   chk("t6_rvalid", o_rvalid, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t6_rdata", o_rdata_out, 0);
`endif
        i_wr = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk); i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("t6_count_post", o_count, 0);
        cyc(1, 8'hA5, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t6_fwft_rvalid", o_rvalid, 1);
        chk("t6_fwft_rdata", o_rdata_out, 8'hA5);
`endif
        exp_q.push_back(8'hA5);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("t6_count_end", o_count, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
